// File: rtl/writeback_ctrl_pkg.sv
// Shared definitions for the writeback stage: source-select codes, load widths,
// FSM state encoding and the captured load context.
package writeback_ctrl_pkg;

    localparam int XLEN = 32;
    localparam int REGW = 5;

    typedef enum logic [2:0] {
        WB_ALU    = 3'b000,
        WB_LOAD   = 3'b001,
        WB_IMM    = 3'b010,
        WB_IADDER = 3'b011,
        WB_CSR    = 3'b100,
        WB_PC4    = 3'b101
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE     = 2'b00,
        LS_HALF     = 2'b01,
        LS_WORD     = 2'b10,
        LS_WORD_ALT = 2'b11
    } load_size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

    // Everything a pending load needs once its response arrives.
    typedef struct packed {
        logic [REGW-1:0] rd;
        logic [1:0]      size;
        logic            unsigned_ld;
        logic [1:0]      lsb;
        logic            wr_en;
    } load_ctx_t;

    function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        logic mis;
        mis = 1'b0;
        case (size)
            LS_HALF:              mis = lsb[0];
            LS_WORD, LS_WORD_ALT: mis = (lsb != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/half/word out of a load response and sign- or
// zero-extends it to a full register value.
module load_extend
    import writeback_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [1:0]      lsb_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        byte_sign;
    logic        half_sign;

    always_comb begin
        byte_v = 8'h00;
        case (lsb_i)
            2'b00:   byte_v = rdata_i[7:0];
            2'b01:   byte_v = rdata_i[15:8];
            2'b10:   byte_v = rdata_i[23:16];
            default: byte_v = rdata_i[31:24];
        endcase
    end

    assign half_v    = lsb_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign byte_sign = byte_v[7] & ~unsigned_i;
    assign half_sign = half_v[15] & ~unsigned_i;

    always_comb begin
        data_o = rdata_i;
        case (size_i)
            LS_BYTE: data_o = {{24{byte_sign}}, byte_v};
            LS_HALF: data_o = {{16{half_sign}}, half_v};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback stage: selects the result source, parks on outstanding loads until
// the data memory answers, and drives a registered register-file write port.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [REGW-1:0] rd_adder_in,
    input  logic            rf_wr_en_in,
    input  logic [2:0]      wb_mux_sel_in,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic [1:0]      addr_lsb_in,
    input  logic [XLEN-1:0] alu_result_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] iadder_in,
    input  logic [XLEN-1:0] pc_plus_4_in,
    input  logic [XLEN-1:0] csr_data_in,
    input  logic [XLEN-1:0] dmem_rdata_in,
    input  logic            dmem_rvalid_in,
    output logic            dmem_rready_out,
    output logic            rf_wr_en_out,
    output logic [REGW-1:0] rf_rd_out,
    output logic [XLEN-1:0] rf_wd_out,
    output logic            stall_out,
    output logic            load_err_out
);

    // Handshake: a bundle transfers on a rising edge with valid_in && ready_out;
    // a load response transfers on a rising edge with dmem_rvalid_in && dmem_rready_out.

    wb_state_e       state_q;
    logic            rf_wr_en_q;
    logic [REGW-1:0] rf_rd_q;
    logic [XLEN-1:0] rf_wd_q;
    logic            load_err_q;
    load_ctx_t       ld_q;
    load_ctx_t       ld_d;

    wb_sel_e         sel;
    logic            sel_valid;
    logic            accept;
    logic            is_load;
    logic            misaligned;
    logic            direct_wr_en;
    logic [XLEN-1:0] wd_mux;
    logic [XLEN-1:0] ld_data;

    // Handshake outputs fall back to their idle values while reset is held.
    assign ready_out       = (state_q == ST_IDLE) || !rst_in;
    assign dmem_rready_out = (state_q == ST_LOAD_WAIT) && rst_in;
    assign stall_out       = (state_q == ST_LOAD_WAIT) && rst_in;

    assign sel        = wb_sel_e'(wb_mux_sel_in);
    assign accept     = valid_in && ready_out;
    assign is_load    = (sel == WB_LOAD);
    assign misaligned = load_misaligned(load_size_in, addr_lsb_in);

    always_comb begin
        wd_mux    = '0;
        sel_valid = 1'b1;
        case (sel)
            WB_ALU:    wd_mux = alu_result_in;
            WB_LOAD:   wd_mux = '0;
            WB_IMM:    wd_mux = imm_in;
            WB_IADDER: wd_mux = iadder_in;
            WB_CSR:    wd_mux = csr_data_in;
            WB_PC4:    wd_mux = pc_plus_4_in;
            default:   sel_valid = 1'b0;
        endcase
    end

    assign direct_wr_en = rf_wr_en_in && (rd_adder_in != '0) && sel_valid;

    always_comb begin
        ld_d             = ld_q;
        ld_d.rd          = rd_adder_in;
        ld_d.size        = load_size_in;
        ld_d.unsigned_ld = load_unsigned_in;
        ld_d.lsb         = addr_lsb_in;
        ld_d.wr_en       = rf_wr_en_in && (rd_adder_in != '0);
    end

    load_extend u_load_extend (
        .rdata_i    (dmem_rdata_in),
        .size_i     (ld_q.size),
        .unsigned_i (ld_q.unsigned_ld),
        .lsb_i      (ld_q.lsb),
        .data_o     (ld_data)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            rf_wr_en_q <= 1'b0;
            rf_rd_q    <= '0;
            rf_wd_q    <= '0;
            load_err_q <= 1'b0;
            ld_q       <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rf_wr_en_q <= 1'b0;
            load_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (is_load) begin
                            if (misaligned) begin
                                load_err_q <= 1'b1;
                            end else begin
                                ld_q    <= ld_d;
                                state_q <= ST_LOAD_WAIT;
                            end
                        end else begin
                            rf_wr_en_q <= direct_wr_en;
                            rf_rd_q    <= rd_adder_in;
                            rf_wd_q    <= wd_mux;
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    if (dmem_rvalid_in) begin
                        rf_wr_en_q <= ld_q.wr_en;
                        rf_rd_q    <= ld_q.rd;
                        rf_wd_q    <= ld_data;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rf_wr_en_out = rf_wr_en_q;
    assign rf_rd_out    = rf_rd_q;
    assign rf_wd_out    = rf_wd_q;
    assign load_err_out = load_err_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl: directed cases plus a random mix, with register-file
// writes checked against a queue of expected {rd, data} results.
module tb_writeback_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  rd_adder_in;
    logic        rf_wr_en_in;
    logic [2:0]  wb_mux_sel_in;
    logic [1:0]  load_size_in;
    logic        load_unsigned_in;
    logic [1:0]  addr_lsb_in;
    logic [31:0] alu_result_in;
    logic [31:0] imm_in;
    logic [31:0] iadder_in;
    logic [31:0] pc_plus_4_in;
    logic [31:0] csr_data_in;
    logic [31:0] dmem_rdata_in;
    logic        dmem_rvalid_in;
    logic        dmem_rready_out;
    logic        rf_wr_en_out;
    logic [4:0]  rf_rd_out;
    logic [31:0] rf_wd_out;
    logic        stall_out;
    logic        load_err_out;

    int n_vec = 0;
    int n_err = 0;
    logic [36:0] exp_q[$];

    writeback_ctrl dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .valid_in         (valid_in),
        .ready_out        (ready_out),
        .rd_adder_in      (rd_adder_in),
        .rf_wr_en_in      (rf_wr_en_in),
        .wb_mux_sel_in    (wb_mux_sel_in),
        .load_size_in     (load_size_in),
        .load_unsigned_in (load_unsigned_in),
        .addr_lsb_in      (addr_lsb_in),
        .alu_result_in    (alu_result_in),
        .imm_in           (imm_in),
        .iadder_in        (iadder_in),
        .pc_plus_4_in     (pc_plus_4_in),
        .csr_data_in      (csr_data_in),
        .dmem_rdata_in    (dmem_rdata_in),
        .dmem_rvalid_in   (dmem_rvalid_in),
        .dmem_rready_out  (dmem_rready_out),
        .rf_wr_en_out     (rf_wr_en_out),
        .rf_rd_out        (rf_rd_out),
        .rf_wd_out        (rf_wd_out),
        .stall_out        (stall_out),
        .load_err_out     (load_err_out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_ext(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic uns, input logic [1:0] lsb);
        logic [31:0] sh;
        logic [31:0] r;
        r = rdata;
        if (size == 2'b00) begin
            sh = rdata >> (8 * lsb);
            r  = uns ? (sh & 32'h0000_00FF) : {{24{sh[7]}}, sh[7:0]};
        end else if (size == 2'b01) begin
            sh = rdata >> (16 * lsb[1]);
            r  = uns ? (sh & 32'h0000_FFFF) : {{16{sh[15]}}, sh[15:0]};
        end
        return r;
    endfunction

    function automatic logic model_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        if (size == 2'b00) return 1'b0;
        if (size == 2'b01) return lsb[0];
        return lsb != 2'b00;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_in) begin
        if (rf_wr_en_out) begin
            logic pending;
            logic [36:0] e;
            pending = (exp_q.size() != 0);
            check("wr_expected", pending, 1'b1);
            if (pending) begin
                e = exp_q.pop_front();
                check("wr_rd_wd", {rf_rd_out, rf_wd_out}, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic scramble_fields();
        rd_adder_in      = 5'($urandom);
        rf_wr_en_in      = 1'($urandom);
        load_size_in     = 2'($urandom);
        load_unsigned_in = 1'($urandom);
        addr_lsb_in      = 2'($urandom);
        alu_result_in    = $urandom;
        imm_in           = $urandom;
        iadder_in        = $urandom;
        pc_plus_4_in     = $urandom;
        csr_data_in      = $urandom;
        dmem_rdata_in    = $urandom;
    endtask

    // Non-load bundle; value v is placed on the source chosen by sel. Ends at a negedge.
    task automatic do_op(input logic [2:0] sel, input logic [4:0] rd, input logic wren,
                         input logic [31:0] v);
        logic exp_w;
        scramble_fields();
        case (sel)
            3'd0: alu_result_in = v;
            3'd2: imm_in        = v;
            3'd3: iadder_in     = v;
            3'd4: csr_data_in   = v;
            3'd5: pc_plus_4_in  = v;
            default: ;
        endcase
        wb_mux_sel_in = sel;
        rd_adder_in   = rd;
        rf_wr_en_in   = wren;
        valid_in      = 1'b1;
        check("ready_before_op", ready_out, 1'b1);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        exp_w = wren && (rd != 5'd0) && (sel <= 3'd5);
        if (exp_w) exp_q.push_back({rd, v});
        scramble_fields();
        @(negedge clk_in);
        check("op_wr_en", rf_wr_en_out, exp_w);
        check("op_rd_reg", rf_rd_out, rd);
        if (sel <= 3'd5) check("op_wd_reg", rf_wd_out, v);
        check("op_no_err", load_err_out, 1'b0);
        check("op_no_stall", stall_out, 1'b0);
    endtask

    // Load bundle; response arrives with the edge ending the delay-th stall cycle.
    task automatic do_load(input logic [4:0] rd, input logic wren, input logic [1:0] size,
                           input logic uns, input logic [1:0] lsb, input logic [31:0] rdata,
                           input int delay);
        logic exp_w;
        scramble_fields();
        wb_mux_sel_in    = 3'b001;
        rd_adder_in      = rd;
        rf_wr_en_in      = wren;
        load_size_in     = size;
        load_unsigned_in = uns;
        addr_lsb_in      = lsb;
        valid_in         = 1'b1;
        check("ready_before_load", ready_out, 1'b1);
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        scramble_fields();
        if (model_misaligned(size, lsb)) begin
            @(negedge clk_in);
            check("mis_err_pulse", load_err_out, 1'b1);
            check("mis_no_wr", rf_wr_en_out, 1'b0);
            check("mis_no_stall", stall_out, 1'b0);
            check("mis_ready", ready_out, 1'b1);
            @(negedge clk_in);
            check("mis_err_clear", load_err_out, 1'b0);
        end else begin
            exp_w = wren && (rd != 5'd0);
            if (exp_w) exp_q.push_back({rd, model_ext(rdata, size, uns, lsb)});
            for (int i = 0; i < delay; i++) begin
                if (i == delay - 1) begin
                    dmem_rvalid_in = 1'b1;
                    dmem_rdata_in  = rdata;
                end
                @(negedge clk_in);
                check("ld_stall", stall_out, 1'b1);
                check("ld_rready", dmem_rready_out, 1'b1);
                check("ld_not_ready", ready_out, 1'b0);
                check("ld_no_early_wr", rf_wr_en_out, 1'b0);
                @(posedge clk_in); #1;
                scramble_fields();
            end
            dmem_rvalid_in = 1'b0;
            @(negedge clk_in);
            check("ld_wr_en", rf_wr_en_out, exp_w);
            check("ld_stall_done", stall_out, 1'b0);
            check("ld_ready_again", ready_out, 1'b1);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        valid_in       = 1'b0;
        dmem_rvalid_in = 1'b0;
        wb_mux_sel_in  = 3'b000;
        scramble_fields();
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        @(negedge clk_in);
        check("rst_wr_en", rf_wr_en_out, 1'b0);
        check("rst_rd", rf_rd_out, 5'd0);
        check("rst_wd", rf_wd_out, 32'd0);
        check("rst_err", load_err_out, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        check("rst_stall", stall_out, 1'b0);
        check("rst_rready", dmem_rready_out, 1'b0);
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // ALU write, latency 1, then strobe drops
        do_op(3'b000, 5'd5, 1'b1, 32'h1234_5678);
        @(negedge clk_in);
        check("alu_wr_drop", rf_wr_en_out, 1'b0);

        // Signed byte load with 3 stall cycles, then back-to-back IMM
        do_load(5'd7, 1'b1, 2'b00, 1'b0, 2'b11, 32'h80AA_BBCC, 3);
        do_op(3'b010, 5'd9, 1'b1, 32'hABCD_0000);

        // Unsigned half from upper lane
        do_load(5'd3, 1'b1, 2'b01, 1'b1, 2'b10, 32'h8001_0000, 2);
        // Signed half lower lane, word load, size 11 as word
        do_load(5'd4, 1'b1, 2'b01, 1'b0, 2'b00, 32'h1234_F00F, 1);
        do_load(5'd6, 1'b1, 2'b10, 1'b0, 2'b00, 32'hDEAD_BEEF, 4);
        do_load(5'd8, 1'b1, 2'b11, 1'b0, 2'b00, 32'h0BAD_F00D, 1);

        // rd=0 never writes; data is still registered
        do_op(3'b101, 5'd0, 1'b1, 32'h0000_0100);
        // Misaligned word and half
        do_load(5'd10, 1'b1, 2'b10, 1'b0, 2'b01, 32'h1111_1111, 1);
        do_load(5'd11, 1'b1, 2'b01, 1'b0, 2'b11, 32'h2222_2222, 1);
        // Reserved select and wr_en=0
        do_op(3'b110, 5'd12, 1'b1, 32'h5555_5555);
        do_op(3'b100, 5'd13, 1'b0, 32'h6666_6666);

        // Response valid in IDLE is ignored
        dmem_rvalid_in = 1'b1;
        repeat (2) begin
            @(negedge clk_in);
            check("idle_rvalid_ready", ready_out, 1'b1);
            check("idle_rvalid_no_wr", rf_wr_en_out, 1'b0);
        end
        dmem_rvalid_in = 1'b0;

        // Reset during LOAD_WAIT coincident with a response
        wb_mux_sel_in = 3'b001;
        rd_adder_in   = 5'd14;
        rf_wr_en_in   = 1'b1;
        load_size_in  = 2'b10;
        addr_lsb_in   = 2'b00;
        valid_in      = 1'b1;
        @(posedge clk_in); #1;
        valid_in = 1'b0;
        @(negedge clk_in);
        check("rst_ld_stall", stall_out, 1'b1);
        rst_in         = 1'b0;
        dmem_rvalid_in = 1'b1;
        dmem_rdata_in  = 32'hCAFE_CAFE;
        #1;
        check("rst_held_ready", ready_out, 1'b1);
        check("rst_held_stall", stall_out, 1'b0);
        check("rst_held_rready", dmem_rready_out, 1'b0);
        @(posedge clk_in); #1;
        rst_in         = 1'b1;
        dmem_rvalid_in = 1'b0;
        @(negedge clk_in);
        check("rst_ld_no_wr", rf_wr_en_out, 1'b0);
        check("rst_ld_ready", ready_out, 1'b1);
        check("rst_ld_idle", stall_out, 1'b0);
        @(negedge clk_in);
        check("rst_ld_no_late_wr", rf_wr_en_out, 1'b0);

        // Random mix
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_load(5'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                        $urandom, $urandom_range(1, 4));
            end else begin
                logic [2:0] s;
                s = 3'($urandom_range(0, 7));
                if (s == 3'b001) s = 3'b000;
                do_op(s, 5'($urandom), 1'($urandom), $urandom);
            end
        end

        repeat (3) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_ctrl.md
WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 The block SHALL have exactly these ports (name, direction, width, meaning), clock and reset first:
- clk_in  in  1  sole clock, rising edge.
- rst_in  in  1  synchronous reset, active-low.
- valid_in  in  1  stage-3 bundle valid.
- ready_out  out  1  block accepts bundle this cycle.
- rd_adder_in  in  5  destination register.
- rf_wr_en_in  in  1  instruction writes register file.
- wb_mux_sel_in  in  3  writeback source select.
- load_size_in  in  2  load width.
- load_unsigned_in  in  1  zero-extend load.
- addr_lsb_in  in  2  load address bits [1:0].
- alu_result_in  in  32  ALU result.
- imm_in  in  32  U-immediate (LUI).
- iadder_in  in  32  PC+imm (AUIPC).
- pc_plus_4_in  in  32  link value.
- csr_data_in  in  32  CSR read data.
- dmem_rdata_in  in  32  load response data.
- dmem_rvalid_in  in  1  load response valid.
- dmem_rready_out  out  1  block accepts load response.
- rf_wr_en_out  out  1  register-file write strobe.
- rf_rd_out  out  5  write address.
- rf_wd_out  out  32  write data.
- stall_out  out  1  upstream pipeline hold.
- load_err_out  out  1  misaligned-load pulse.

Function
REQ-002 A bundle SHALL be accepted at a rising edge where valid_in=1 and ready_out=1.
REQ-003 wb_mux_sel encoding: 000 ALU, 001 LOAD, 010 IMM, 011 IADDER, 100 CSR, 101 PC+4; 110/111 reserved.
REQ-004 FSM states SHALL be IDLE and LOAD_WAIT; ready_out=1 only in IDLE; dmem_rready_out=1 and stall_out=1 only in LOAD_WAIT.
REQ-005 A non-load accept at edge N SHALL drive rf_wr_en_out/rf_rd_out/rf_wd_out, registered, for exactly the cycle after N (latency 1); state stays IDLE.
REQ-006 An aligned load accept (sel=001) SHALL move IDLE->LOAD_WAIT with no write issued.
REQ-007 In LOAD_WAIT, an edge with dmem_rvalid_in=1 SHALL register the extended load data as the write for the next cycle and return to IDLE; back-to-back accept is allowed in that next cycle.
REQ-008 LOAD_WAIT SHALL persist indefinitely while dmem_rvalid_in=0; dmem_rvalid_in in IDLE SHALL be ignored.
REQ-009 Load extraction: byte = rdata[8*lsb+7:8*lsb]; half = rdata[16*lsb[1]+15:16*lsb[1]]; word = rdata; load_size 11 treated as word.
REQ-010 Byte/half SHALL sign-extend from the top bit unless load_unsigned_in=1, then zero-extend.
REQ-011 Misaligned load (half with lsb[0]=1, word with lsb!=00) SHALL stay IDLE, issue no write, and pulse load_err_out for one cycle after accept.
REQ-012 rf_wr_en_out SHALL be 0 when rf_wr_en_in=0, rd_adder_in=0, or sel reserved; rf_rd_out/rf_wd_out still registered.
REQ-013 rf_wr_en_out and load_err_out SHALL be 0 in every cycle not named by REQ-005/007/011.
REQ-014 Load parameters (rd, size, unsigned, lsb, wr_en) SHALL be captured at accept and used at response, independent of later inputs.

Reset
REQ-015 rst_in=0 at an edge SHALL force state IDLE and all registered outputs (rf_wr_en_out, rf_rd_out, rf_wd_out, load_err_out) to 0.
REQ-016 Reset during LOAD_WAIT SHALL abandon the load with no write; a concurrent dmem_rvalid_in is discarded.
REQ-017 While rst_in=0, ready_out, dmem_rready_out and stall_out SHALL read their IDLE values (1,0,0).

Structure
REQ-018 wb_mux_sel codes, load_size codes and FSM state encoding SHALL live in the shared core package.
REQ-019 Load alignment/extension (REQ-009/010) SHALL be one combinational sub-module, load_extend.

Verification
REQ-020 ALU: sel=000, rd=5, alu=0x1234_5678 -> one cycle later wr_en=1, rd=5, wd=0x1234_5678, then wr_en=0.
REQ-021 Signed byte: sel=001, size=00, lsb=11, unsigned=0, rvalid after 3 cycles with rdata=0x80AA_BBCC -> stall 3 cycles, then wd=0xFFFF_FF80.
REQ-022 Unsigned half: size=01, lsb=10, unsigned=1, rdata=0x8001_0000 -> wd=0x0000_8001.
REQ-023 rd=0, sel=101, pc+4=0x100 -> wr_en stays 0; misaligned word lsb=01 -> load_err_out 1 cycle, no stall, no write.
REQ-024 Reset asserted in LOAD_WAIT coincident with rvalid=1 -> next cycle state IDLE, wr_en=0, ready_out=1.
